c7blsu_ctl: RTL and testbench
=============================

Name: c7blsu_ctl

Overview:
Load/store unit control for the c7b core, sitting between the execution control logic and the bus interface unit.
- Accepts one memory op per `lsu_vld_e` pulse and checks alignment in LS1.
- Runs a single request/ack transaction on the BIU port, with a timeout.
- Returns exactly one LS3 completion pulse, which the ECL uses to end its IFU stall: data valid, write finished, bus error or ECC error.
- An ALE exception ends the op in LS1 instead, with no LS3 pulse.

Parameters:
AW, 32, address width
DW, 32, data width (fixed 32; byte lanes = 4)
TIMEOUT, 64, max cycles waiting for `biu_ack` before forcing bus error (≥2)

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
lsu_vld_e  in  1  op valid in E stage (single-cycle pulse)
lsu_op_e  in  1  0=load, 1=store
lsu_size_e  in  2  0=byte, 1=half, 2=word, 3=reserved
lsu_sign_e  in  1  load sign-extend
lsu_addr_e  in  AW  byte address
lsu_wdata_e  in  DW  store data, right-aligned
lsu_except_ale_ls1  out  1  misaligned-access exception pulse
lsu_except_buserr_ls3  out  1  bus error / timeout pulse
lsu_except_ecc_ls3  out  1  read parity error pulse
lsu_data_valid_ls3  out  1  load data valid pulse
lsu_wr_fin_ls3  out  1  store complete pulse
lsu_rdata_ls3  out  DW  aligned, extended load data
lsu_fault_addr_ls3  out  AW  op address, held until next op
lsu_busy  out  1  op in flight
biu_req  out  1  bus request
biu_we  out  1  write enable
biu_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
biu_wstrb  out  4  byte strobes
biu_wdata  out  DW  lane-replicated store data
biu_ack  in  1  transaction done
biu_rdata  in  DW  read data
biu_err  in  1  error, valid with ack

Behaviour:
- Reset: all outputs 0; FSM=IDLE; timeout counter=0.
- Reset is asynchronous. Mid-op reset drops `biu_req` immediately and emits no LS3 pulse.
- FSM states: IDLE, LS1, WAIT, LS3.
- IDLE:
  - `lsu_vld_e`=1 at posedge: capture op/size/sign/addr/wdata, go LS1.
  - `biu_ack` in IDLE is ignored.
- Alignment: ALE if size=1 & addr[0]; size=2 & addr[1:0]≠0; size=3 (any address).
- LS1, ALE case:
  - `lsu_except_ale_ls1`=1 for this one cycle; no bus request; next state IDLE.
- LS1, aligned case:
  - `biu_req`=1 with addr/we/wstrb/wdata stable; `lsu_busy`=1.
  - `biu_ack` this cycle → LS3; else → WAIT.
- WAIT:
  - `biu_req` held with all bus outputs stable; counter increments each cycle.
  - `biu_ack` → LS3 and counter clears.
  - counter == TIMEOUT-1 with no ack → LS3 with timeout flag; `biu_req` drops.
- Ack cycle: `biu_req` deasserts the cycle after `biu_ack` is sampled.
- LS3: exactly one one-cycle pulse, then IDLE. Priority, highest first:
  1. `lsu_except_buserr_ls3` if `biu_err` at ack or timeout;
  2. `lsu_except_ecc_ls3` (feature only);
  3. `lsu_wr_fin_ls3` for a store;
  4. `lsu_data_valid_ls3` for a load.
- Minimum latency: `lsu_vld_e` at edge k → LS1 in cycle k+1 → LS3 pulse in cycle k+2 (ack during LS1).
- Store strobes: byte → 4'b0001<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
- Store data: byte replicated ×4, half replicated ×2, word as-is.
- Load data:
  - `biu_rdata` >> (8*addr[1:0]), masked to size.
  - Sign-extended if `lsu_sign_e`, else zero-extended.
  - Registered into `lsu_rdata_ls3` at ack; held until next load ack.
  - Not updated on bus error.
- `lsu_vld_e` while `lsu_busy`: ignored (ECL guarantees stall). `lsu_busy`=1 in LS1 (aligned), WAIT and LS3.
- `lsu_fault_addr_ls3` loads the op address on capture.

Optional Feature:
- Macro: C7BLSU_PARITY_EN.
- With the macro:
  - Extra input `biu_rpar` [3:0], one even parity bit per byte of `biu_rdata`.
  - On a load ack with no `biu_err`, any byte-parity mismatch (all 4 bytes checked) → `lsu_except_ecc_ls3` pulse instead of `lsu_data_valid_ls3`.
  - Stores are never checked.
- Without the macro: no `biu_rpar` port; `lsu_except_ecc_ls3` tied 0.

Test Plan:
- Word load addr=0x100, ack in LS1 with rdata=0xDEADBEEF → `lsu_data_valid_ls3`=1 at k+2, rdata=0xDEADBEEF, `biu_addr`=0x100.
- Signed byte load addr=0x103, rdata=0x80112233 → rdata_ls3=0xFFFFFF80; unsigned → 0x00000080.
- Half store addr=0x202, wdata=0x1234, ack after 3 WAIT cycles → wstrb=4'b1100, wdata=0x12341234, `lsu_wr_fin_ls3` pulse, `biu_req` high 4 cycles.
- Word load addr=0x101 → `lsu_except_ale_ls1` at k+1, `biu_req` never asserted, no LS3 pulse, `lsu_busy`=0.
- Load with `biu_err`=1 at ack → `lsu_except_buserr_ls3` only; no ack for TIMEOUT=64 cycles → buserr pulse, `biu_req` drops, fault_addr=op addr.
- Feature on: load rdata=0x00000001, rpar=4'b0000 → `lsu_except_ecc_ls3`=1, `lsu_data_valid_ls3`=0. Reset asserted in WAIT → `biu_req`=0 immediately; a later ack is ignored.

Source files
------------

// File: rtl/c7blsu_ctl.sv
// c7b load/store unit control: alignment check, single BIU transaction with timeout, LS3 completion pulse.
// Optional read parity checking is built when C7BLSU_PARITY_EN is defined.
module c7blsu_ctl #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          lsu_vld_e,
   input  logic          lsu_op_e,
   input  logic [1:0]    lsu_size_e,
   input  logic          lsu_sign_e,
   input  logic [AW-1:0] lsu_addr_e,
   input  logic [DW-1:0] lsu_wdata_e,
   output logic          lsu_except_ale_ls1,
   output logic          lsu_except_buserr_ls3,
   output logic          lsu_except_ecc_ls3,
   output logic          lsu_data_valid_ls3,
   output logic          lsu_wr_fin_ls3,
   output logic [DW-1:0] lsu_rdata_ls3,
   output logic [AW-1:0] lsu_fault_addr_ls3,
   output logic          lsu_busy,
   output logic          biu_req,
   output logic          biu_we,
   output logic [AW-1:0] biu_addr,
   output logic [3:0]    biu_wstrb,
   output logic [DW-1:0] biu_wdata,
   input  logic          biu_ack,
   input  logic [DW-1:0] biu_rdata,
`ifdef C7BLSU_PARITY_EN
   input  logic [3:0]    biu_rpar,
`endif
   input  logic          biu_err
);

   // state  | meaning
   // S_IDLE | waiting for lsu_vld_e
   // S_LS1  | alignment check; ALE pulse or first bus request cycle
   // S_WAIT | request held, counting toward timeout
   // S_LS3  | one-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_LS1, S_WAIT, S_LS3} state_t;

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          op_q, sign_q, err_q, ecc_q;
   logic [1:0]    size_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, rdata_q;
   logic          ale, capture, done, tmo, par_bad;
   logic [DW-1:0] rd_sh, rd_ext;
   logic [3:0]    strb;

   assign ale = (size_q == 2'd3) ||
                ((size_q == 2'd1) && addr_q[0]) ||
                ((size_q == 2'd2) && (addr_q[1:0] != 2'b00));

   assign capture = (state_q == S_IDLE) && lsu_vld_e;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      tmo     = 1'b0;
      case (state_q)
         S_IDLE: if (lsu_vld_e) state_d = S_LS1;
         S_LS1: begin
            if (ale) state_d = S_IDLE;
            else if (biu_ack) begin
               state_d = S_LS3;
               done    = 1'b1;
            end else state_d = S_WAIT;
         end
         S_WAIT: begin
            if (biu_ack) begin
               state_d = S_LS3;
               done    = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TC) begin
               state_d = S_LS3;
               tmo     = 1'b1;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_LS3:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign rd_sh = biu_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (size_q)
         2'd0:    rd_ext = {{24{sign_q & rd_sh[7]}}, rd_sh[7:0]};
         2'd1:    rd_ext = {{16{sign_q & rd_sh[15]}}, rd_sh[15:0]};
         default: rd_ext = rd_sh;
      endcase
   end

   always_comb begin
      case (size_q)
         2'd0:    strb = 4'b0001 << addr_q[1:0];
         2'd1:    strb = 4'b0011 << addr_q[1:0];
         default: strb = 4'b1111;
      endcase
   end

`ifdef C7BLSU_PARITY_EN
   // Even parity: each rpar bit equals the XOR of its byte.
   assign par_bad = (biu_rpar != {^biu_rdata[31:24], ^biu_rdata[23:16],
                                  ^biu_rdata[15:8],  ^biu_rdata[7:0]});
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         sign_q  <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ecc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            op_q    <= lsu_op_e;
            sign_q  <= lsu_sign_e;
            size_q  <= lsu_size_e;
            addr_q  <= lsu_addr_e;
            wdata_q <= lsu_wdata_e;
         end
         if (done) begin
            err_q <= biu_err;
            ecc_q <= par_bad && !op_q && !biu_err;
            if (!op_q && !biu_err) rdata_q <= rd_ext;
         end else if (tmo) begin
            err_q <= 1'b1;
            ecc_q <= 1'b0;
         end
      end
   end

   assign lsu_except_ale_ls1    = (state_q == S_LS1) && ale;
   assign lsu_except_buserr_ls3 = (state_q == S_LS3) && err_q;
`ifdef C7BLSU_PARITY_EN
   assign lsu_except_ecc_ls3    = (state_q == S_LS3) && !err_q && ecc_q;
`else
   assign lsu_except_ecc_ls3    = 1'b0;
`endif
   assign lsu_wr_fin_ls3        = (state_q == S_LS3) && !err_q && op_q;
   assign lsu_data_valid_ls3    = (state_q == S_LS3) && !err_q && !ecc_q && !op_q;
   assign lsu_rdata_ls3         = rdata_q;
   assign lsu_fault_addr_ls3    = addr_q;
   assign lsu_busy              = ((state_q == S_LS1) && !ale) || (state_q == S_WAIT) ||
                                  (state_q == S_LS3);

   assign biu_req   = ((state_q == S_LS1) && !ale) || (state_q == S_WAIT);
   assign biu_we    = op_q;
   assign biu_addr  = {addr_q[AW-1:2], 2'b00};
   assign biu_wstrb = biu_req ? strb : 4'b0000;

   always_comb begin
      case (size_q)
         2'd0:    biu_wdata = {4{wdata_q[7:0]}};
         2'd1:    biu_wdata = {2{wdata_q[15:0]}};
         default: biu_wdata = wdata_q;
      endcase
   end

endmodule

// File: tb/tb_c7blsu_ctl.sv
// Randomized self-checking bench for c7blsu_ctl against a behavioural model of each op.
module tb_c7blsu_ctl;
   localparam int AW = 32, DW = 32, TIMEOUT = 64;

   logic          clk = 1'b0, resetn = 1'b0;
   logic          lsu_vld_e = 0, lsu_op_e = 0, lsu_sign_e = 0;
   logic [1:0]    lsu_size_e = 0;
   logic [AW-1:0] lsu_addr_e = 0;
   logic [DW-1:0] lsu_wdata_e = 0;
   logic          ale, buserr, ecc, dvalid, wrfin, busy, biu_req, biu_we;
   logic [DW-1:0] rdata_ls3, biu_wdata;
   logic [AW-1:0] fault_addr, biu_addr;
   logic [3:0]    biu_wstrb;
   logic          biu_ack = 0, biu_err = 0;
   logic [DW-1:0] biu_rdata = 0;
`ifdef C7BLSU_PARITY_EN
   logic [3:0]    biu_rpar = 0;
`endif

   int total = 0, bad = 0;
   logic [31:0] exp_rdata = 0;

   c7blsu_ctl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .resetn(resetn),
      .lsu_vld_e(lsu_vld_e), .lsu_op_e(lsu_op_e), .lsu_size_e(lsu_size_e),
      .lsu_sign_e(lsu_sign_e), .lsu_addr_e(lsu_addr_e), .lsu_wdata_e(lsu_wdata_e),
      .lsu_except_ale_ls1(ale), .lsu_except_buserr_ls3(buserr), .lsu_except_ecc_ls3(ecc),
      .lsu_data_valid_ls3(dvalid), .lsu_wr_fin_ls3(wrfin), .lsu_rdata_ls3(rdata_ls3),
      .lsu_fault_addr_ls3(fault_addr), .lsu_busy(busy),
      .biu_req(biu_req), .biu_we(biu_we), .biu_addr(biu_addr), .biu_wstrb(biu_wstrb),
      .biu_wdata(biu_wdata), .biu_ack(biu_ack), .biu_rdata(biu_rdata),
`ifdef C7BLSU_PARITY_EN
      .biu_rpar(biu_rpar),
`endif
      .biu_err(biu_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_ale(input int size, input logic [31:0] a);
      return (size == 3) || (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0);
   endfunction

   function automatic logic [3:0] exp_strb(input int size, input logic [31:0] a);
      int s;
      if (size == 0) s = 1 << (a % 4);
      else if (size == 1) s = 3 << (a % 4);
      else s = 15;
      return 4'(s);
   endfunction

   function automatic logic [31:0] exp_wdata(input int size, input logic [31:0] w);
      if (size == 0) return (w & 32'hFF) * 32'h01010101;
      if (size == 1) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] exp_load(input int size, input bit sgn,
                                            input logic [31:0] a, input logic [31:0] r);
      int nbytes;
      logic [63:0] v, mask;
      nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
      v      = 64'(r) >> (8 * (a % 4));
      mask   = (64'd1 << (8 * nbytes)) - 64'd1;
      v      = v & mask;
      if (sgn && v[8*nbytes-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   // d = cycle (0 = LS1) in which ack is given; d > TIMEOUT means never.
   task automatic do_op(input bit op, input int size, input bit sgn, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] r, input bit err,
                        input int d, input bit par_corrupt);
      bit m_ale, m_err, m_ecc, acked;
      @(negedge clk);
      lsu_vld_e = 1; lsu_op_e = op; lsu_size_e = 2'(size); lsu_sign_e = sgn;
      lsu_addr_e = a; lsu_wdata_e = w;
      @(negedge clk);
      lsu_vld_e = 0;
      lsu_addr_e = $urandom; lsu_wdata_e = $urandom;
      m_ale = is_ale(size, a);
      if (m_ale) begin
         check_val("ale_pulse", ale, 1);
         check_val("ale_req", biu_req, 0);
         check_val("ale_busy", busy, 0);
         @(negedge clk);
         check_val("ale_once", ale, 0);
         check_val("ale_no_ls3", {buserr, ecc, dvalid, wrfin}, 0);
         check_val("ale_req_after", biu_req, 0);
         check_val("ale_fault_addr", fault_addr, a);
         return;
      end
      check_val("ls1_ale", ale, 0);
      acked = 0;
      for (int j = 0; j <= TIMEOUT; j++) begin
         check_val("req_hi", biu_req, 1);
         check_val("busy_hi", busy, 1);
         check_val("biu_addr", biu_addr, {a[31:2], 2'b00});
         check_val("biu_we", biu_we, op);
         check_val("no_early_ls3", {buserr, ecc, dvalid, wrfin}, 0);
         if (op) begin
            check_val("wstrb", biu_wstrb, exp_strb(size, a));
            check_val("wdata", biu_wdata, exp_wdata(size, w));
         end
         biu_ack = (j == d); biu_err = err; biu_rdata = r;
`ifdef C7BLSU_PARITY_EN
         biu_rpar = {^r[31:24], ^r[23:16], ^r[15:8], ^r[7:0]} ^ {3'b000, par_corrupt};
`endif
         acked = (j == d);
         @(negedge clk);
         biu_ack = 0; biu_err = $urandom; biu_rdata = $urandom;
         if (acked) break;
      end
      m_err = !acked || err;
`ifdef C7BLSU_PARITY_EN
      m_ecc = !m_err && !op && par_corrupt;
`else
      m_ecc = 0;
`endif
      if (acked && !err && !op) exp_rdata = exp_load(size, sgn, a, r);
      check_val("ls3_req_low", biu_req, 0);
      check_val("ls3_busy", busy, 1);
      check_val("ls3_buserr", buserr, m_err);
      check_val("ls3_ecc", ecc, m_ecc);
      check_val("ls3_wrfin", wrfin, !m_err && op);
      check_val("ls3_dvalid", dvalid, !m_err && !m_ecc && !op);
      check_val("ls3_rdata", rdata_ls3, exp_rdata);
      check_val("ls3_fault_addr", fault_addr, a);
      @(negedge clk);
      check_val("idle_pulses", {buserr, ecc, dvalid, wrfin}, 0);
      check_val("idle_busy", busy, 0);
      check_val("idle_req", biu_req, 0);
      check_val("idle_fault_addr", fault_addr, a);
   endtask

   initial begin
      int r, d;
      #12;
      check_val("rst_outs", {ale, buserr, ecc, dvalid, wrfin, busy, biu_req, biu_we, biu_wstrb}, 0);
      check_val("rst_data", {rdata_ls3, fault_addr, biu_addr, biu_wdata}, 0);
      @(negedge clk);
      resetn = 1;

      do_op(0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
      do_op(0, 0, 1, 32'h103, 0, 32'h80112233, 0, 0, 0);
      do_op(0, 0, 0, 32'h103, 0, 32'h80112233, 0, 1, 0);
      do_op(1, 1, 0, 32'h202, 32'h1234, 0, 0, 3, 0);
      do_op(0, 2, 0, 32'h101, 0, 0, 0, 0, 0);
      do_op(0, 3, 0, 32'h100, 0, 0, 0, 0, 0);
      do_op(0, 2, 0, 32'h400, 0, 32'h55AA55AA, 1, 2, 0);
      do_op(0, 2, 0, 32'h404, 0, 0, 0, TIMEOUT + 1, 0);
      do_op(0, 1, 1, 32'h406, 0, 32'h8001FFFF, 0, TIMEOUT, 0);
      do_op(0, 2, 0, 32'h500, 0, 32'h00000001, 0, 0, 1);

      for (int i = 0; i < 60; i++) begin
         r = $urandom % 10;
         if (r < 7) d = $urandom % 4;
         else if (r == 7) d = TIMEOUT;
         else if (r == 8) d = TIMEOUT + 1;
         else d = $urandom % 20;
         do_op($urandom % 2, $urandom % 4, $urandom % 2, $urandom, $urandom, $urandom,
               ($urandom % 5) == 0, d, ($urandom % 4) == 0);
      end

      // ack in idle must be ignored
      @(negedge clk);
      biu_ack = 1; biu_rdata = 32'hCAFEF00D;
      @(negedge clk);
      biu_ack = 0;
      check_val("idle_ack_ignored", {busy, biu_req, buserr, dvalid, wrfin}, 0);
      check_val("idle_ack_rdata", rdata_ls3, exp_rdata);

      // reset in WAIT: request drops immediately, later ack ignored
      @(negedge clk);
      lsu_vld_e = 1; lsu_op_e = 0; lsu_size_e = 2; lsu_addr_e = 32'h300;
      @(negedge clk);
      lsu_vld_e = 0;
      @(negedge clk);
      check_val("wait_req", biu_req, 1);
      #2 resetn = 0;
      #1;
      check_val("async_rst_req", biu_req, 0);
      check_val("async_rst_busy", busy, 0);
      @(negedge clk);
      resetn = 1;
      biu_ack = 1; biu_rdata = 32'h12345678;
      @(negedge clk);
      biu_ack = 0;
      check_val("post_rst_pulses", {buserr, ecc, dvalid, wrfin, ale}, 0);
      check_val("post_rst_req", {biu_req, busy}, 0);
      check_val("post_rst_rdata", rdata_ls3, 0);
      exp_rdata = 0;
      do_op(0, 2, 0, 32'h600, 0, 32'hA5A5A5A5, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
